drum_timing_sequencer: RTL and testbench
========================================

# drum_timing_sequencer

- Upstream address source for the drum timing memory.
- Generates the 6-bit drum-position address plus the memory enables (`ce_n`, `oe_n`, `we_n`), and advances one position per `clk`.
- Wraps at end of rotation and counts rotations; supports free-run, fixed-count and single-step operation.
- Consumes the timing memory's `resetCounter_n` strobe as the end-of-rotation indication.

## Interface
- `NUM_POSITIONS`, 60, drum positions per rotation (safety wrap bound).
- `ADDR_W`, 6, address width.
- `ROT_W`, 8, rotation-count width.
- `clk` in 1: system clock; also the timing memory's half-phase select.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `start` in 1: one-cycle pulse; begins a run when idle.
- `stop` in 1: one-cycle pulse; requests halt at end of current rotation.
- `step_mode` in 1: 1 = advance only on `step_req`.
- `step_req` in 1: one-cycle pulse; advance one position in step mode.
- `num_rotations` in ROT_W: rotations to run; 0 = run until `stop`; sampled on `start`.
- `reset_counter_n` in 1: timing memory `resetCounter_n`; low = last position of rotation.
- `addr` out ADDR_W: drum position to timing memory.
- `ce_n`, `oe_n` out 1: memory chip/output enable, active-low.
- `we_n` out 1: constant 1 (memory is read-only in this design).
- `busy` out 1: high in RUN or STOPPING.
- `rotation_tick` out 1: one-cycle pulse on each wrap.
- `done` out 1: one-cycle pulse when returning to IDLE.
- `rotations_left` out ROT_W: remaining rotations.

## Operation
- States: IDLE, RUN, STOPPING.
- IDLE:
  - `ce_n` = `oe_n` = 1, `addr` = 0.
  - `start` → RUN; loads `rotations_left` ← `num_rotations`; `addr` stays 0 for the first active cycle.
- Advance enable `adv` = `!step_mode || step_req`, evaluated only in RUN/STOPPING.
- Wrap condition `wrap` = `adv && (!reset_counter_n || addr == NUM_POSITIONS-1)`:
  - On `wrap`: `addr` ← 0 and `rotation_tick` = 1.
  - Otherwise, on `adv`: `addr` ← `addr` + 1.
- Count handling on `wrap`:
  - If `rotations_left` > 1: decrement.
  - If `rotations_left` == 1: decrement to 0, → IDLE, `done` = 1.
  - If `rotations_left` == 0 (continuous): hold at 0, stay.
- `stop` in RUN → STOPPING. STOPPING behaves like RUN, but the next `wrap` → IDLE with `done` = 1. `stop` in IDLE or STOPPING is ignored.
- `start` while `busy` is ignored.
- Simultaneous `stop` and `wrap` in RUN: the wrap is final → IDLE, `done`.
- `reset_counter_n` is sampled only while `ce_n` = 0 (memory tri-states when disabled); ignore X/Z in IDLE.
- `step_req` with `step_mode` = 0 has no extra effect. Toggling `step_mode` mid-rotation takes effect next cycle without an address glitch.

## Timing
- All state, `addr`, `ce_n`, `oe_n`, `rotation_tick`, `done` and `rotations_left` are registered and update on the rising `clk` edge only. `addr` is stable for a full `clk` period so the memory's `clk`-LSB half-phases both see the same position.
- Reset values: state IDLE, `addr` 0, `ce_n` 1, `oe_n` 1, `we_n` 1, `busy` 0, `rotation_tick` 0, `done` 0, `rotations_left` 0.
- `rst_n` asserted mid-rotation forces reset values immediately (asynchronous). No `done` pulse.
- `start` at edge N: `ce_n`/`oe_n` low and `busy` high from edge N; `addr` 0 during cycle N..N+1; `addr` 1 after edge N+1 (free-run).
- A full rotation in free-run is exactly `NUM_POSITIONS` cycles. `rotation_tick` asserts in the cycle after `addr` = 59.
- `done` asserts in the same cycle `busy` falls. `ce_n`/`oe_n` return high on that edge.

## Structure
- Shared package `abc_timing_pkg`:
  - `NUM_POSITIONS`, `ADDR_W`;
  - the state enum (IDLE/RUN/STOPPING);
  - the strobe bit positions used by the timing memory (read 0, control 1, lastRead 2, lastWrite 3, clearControl 4, check 5, clearFlags 6, resetCounter_n 7).
- One natural sub-module: `position_counter` (modulo-N up counter with enable, sync clear, wrap flag); the FSM and rotation counter live in the top.

## Test plan
- Reset, then `start` with `num_rotations` = 2, `step_mode` = 0 → `addr` 0..59 twice, two `rotation_tick` pulses 60 cycles apart, `done` at the second wrap, `rotations_left` 2→1→0.
- `num_rotations` = 0, `stop` pulsed at `addr` 20 → `busy` holds until `addr` 59 wraps, then `done`; total 60 further positions after start of that rotation.
- Timing-memory model drives `reset_counter_n` low at `addr` 59 and also (fault injection) at `addr` 30 → early wrap at 30, `rotation_tick` fires, `addr` → 0.
- `step_mode` = 1, three `step_req` pulses spaced 5 cycles apart → `addr` 0→1→2→3, unchanged between pulses; `ce_n` low throughout.
- `rst_n` asserted asynchronously at `addr` 37 mid-run → all outputs take reset values before the next edge; no `done`; subsequent `start` restarts at `addr` 0.
- `start` during RUN and `stop` coincident with final wrap → `start` ignored, single `done`, IDLE.

Source files
------------

// File: rtl/abc_timing_pkg.sv
// Shared definitions for the drum timing path: geometry, sequencer states and
// the bit positions of the strobes stored in the timing memory words.
package abc_timing_pkg;

    localparam int NUM_POSITIONS = 60;
    localparam int ADDR_W        = 6;
    localparam int ROT_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } seq_state_e;

    // Strobe bit positions inside a timing memory data word
    localparam int STB_READ            = 0;
    localparam int STB_CONTROL         = 1;
    localparam int STB_LAST_READ       = 2;
    localparam int STB_LAST_WRITE      = 3;
    localparam int STB_CLEAR_CONTROL   = 4;
    localparam int STB_CHECK           = 5;
    localparam int STB_CLEAR_FLAGS     = 6;
    localparam int STB_RESET_COUNTER_N = 7;
    localparam int STB_W               = 8;

endpackage

// File: rtl/drum_timing_sequencer_if.sv
// Control and timing-memory signals of the drum timing sequencer.
// slave is the sequencer side; master is the controller/memory side.
interface drum_timing_sequencer_if #(
    parameter int ADDR_W = abc_timing_pkg::ADDR_W,
    parameter int ROT_W  = abc_timing_pkg::ROT_W
) ();

    logic              start;
    logic              stop;
    logic              step_mode;
    logic              step_req;
    logic [ROT_W-1:0]  num_rotations;
    logic              reset_counter_n;
    logic [ADDR_W-1:0] addr;
    logic              ce_n;
    logic              oe_n;
    logic              we_n;
    logic              busy;
    logic              rotation_tick;
    logic              done;
    logic [ROT_W-1:0]  rotations_left;

    modport slave (
        input  start, stop, step_mode, step_req, num_rotations, reset_counter_n,
        output addr, ce_n, oe_n, we_n, busy, rotation_tick, done, rotations_left
    );

    modport master (
        output start, stop, step_mode, step_req, num_rotations, reset_counter_n,
        input  addr, ce_n, oe_n, we_n, busy, rotation_tick, done, rotations_left
    );

endinterface

// File: rtl/drum_timing_sequencer_position_counter.sv
// Modulo-N drum position counter with advance enable, synchronous clear and an
// externally forced early wrap; wrap_o flags the cycle that returns to zero.
module position_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         force_wrap_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap_o  = en_i && (force_wrap_i || (count_q == LAST));
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i || wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/drum_timing_sequencer.sv
// Drum timing sequencer: walks the timing memory address once per clk, wraps at
// end of rotation and runs free, for a fixed rotation count, or single-stepped.
module drum_timing_sequencer #(
    parameter int NUM_POSITIONS = abc_timing_pkg::NUM_POSITIONS,
    parameter int ADDR_W        = abc_timing_pkg::ADDR_W,
    parameter int ROT_W         = abc_timing_pkg::ROT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    drum_timing_sequencer_if.slave  bus
);

    import abc_timing_pkg::*;

    seq_state_e        state_q;
    logic [ROT_W-1:0]  rot_left_q;
    logic              ce_n_q;
    logic              oe_n_q;
    logic              tick_q;
    logic              done_q;

    logic              active;
    logic              adv;
    logic              mem_last;
    logic              wrap;
    logic              final_wrap;
    logic [ADDR_W-1:0] pos;

    assign active = (state_q != ST_IDLE);
    assign adv    = active && (!bus.step_mode || bus.step_req);

    // The memory only drives resetCounter_n while enabled, so an undriven
    // level while idle never reaches the wrap logic.
    assign mem_last = !ce_n_q && !bus.reset_counter_n;

    position_counter #(
        .N (NUM_POSITIONS),
        .W (ADDR_W)
    ) u_position_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (adv),
        .clr_i        (!active),
        .force_wrap_i (mem_last),
        .count_o      (pos),
        .wrap_o       (wrap)
    );

    // A stop arriving on the wrap cycle makes that wrap the last one.
    assign final_wrap = wrap && ((state_q == ST_STOPPING) || bus.stop ||
                                 (rot_left_q == ROT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rot_left_q <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tick_q <= wrap;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_RUN;
                        rot_left_q <= bus.num_rotations;
                        ce_n_q     <= 1'b0;
                        oe_n_q     <= 1'b0;
                    end
                end
                ST_RUN, ST_STOPPING: begin
                    // A count of zero means continuous and is held at zero
                    if (wrap && (rot_left_q != '0)) begin
                        rot_left_q <= rot_left_q - ROT_W'(1);
                    end
                    if (final_wrap) begin
                        state_q <= ST_IDLE;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end else if ((state_q == ST_RUN) && bus.stop) begin
                        state_q <= ST_STOPPING;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.addr           = pos;
    assign bus.ce_n           = ce_n_q;
    assign bus.oe_n           = oe_n_q;
    assign bus.we_n           = 1'b1;
    assign bus.busy           = active;
    assign bus.rotation_tick  = tick_q;
    assign bus.done           = done_q;
    assign bus.rotations_left = rot_left_q;

endmodule

// File: tb/tb_drum_timing_sequencer.sv
// Self-checking bench for drum_timing_sequencer: directed scenarios plus a
// randomized phase, all compared cycle by cycle against a rotation-level model.
module tb_drum_timing_sequencer;

    import abc_timing_pkg::*;

    localparam int NP = NUM_POSITIONS;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    drum_timing_sequencer_if bus ();

    drum_timing_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // stimulus
    bit         s_start, s_stop, s_step_mode, s_step_req;
    logic [7:0] s_nr;
    int         s_fault_addr = -1;

    // reference model: one drum rotation at a time, plain arithmetic
    bit m_busy, m_stopping, m_tick, m_done;
    int m_addr, m_rl;

    // bookkeeping from observed outputs
    int cycle_no, ticks, dones, last_tick_cycle, tick_gap, done_cycle, rl_at_tick1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_stopping = 0; m_tick = 0; m_done = 0; m_addr = 0; m_rl = 0;
    endtask

    task automatic step();
        logic rcn;
        bit   last;
        if (m_busy) rcn = !((m_addr == NP - 1) || (m_addr == s_fault_addr));
        else        rcn = 1'bx;
        bus.start           = s_start;
        bus.stop            = s_stop;
        bus.step_mode       = s_step_mode;
        bus.step_req        = s_step_req;
        bus.num_rotations   = s_nr;
        bus.reset_counter_n = rcn;

        m_tick = 0;
        m_done = 0;
        if (!m_busy) begin
            if (s_start) begin
                m_busy = 1; m_stopping = 0; m_rl = int'(s_nr);
            end
        end else begin
            if (!s_step_mode || s_step_req) begin
                if (rcn == 1'b0) begin
                    m_tick = 1;
                    m_addr = 0;
                    last = m_stopping || s_stop || (m_rl == 1);
                    if (m_rl > 0) m_rl--;
                    if (last) begin
                        m_busy = 0; m_stopping = 0; m_done = 1;
                    end
                end else begin
                    m_addr = (m_addr + 1) % NP;
                end
            end
            if (m_busy && s_stop) m_stopping = 1;
        end

        @(posedge clk);
        #1;
        cycle_no++;
        chk("cycle",
            32'({bus.addr, bus.ce_n, bus.oe_n, bus.we_n, bus.busy,
                 bus.rotation_tick, bus.done, bus.rotations_left}),
            32'({6'(m_addr), !m_busy, !m_busy, 1'b1, m_busy, m_tick, m_done, 8'(m_rl)}));
        if (bus.rotation_tick === 1'b1) begin
            if (ticks > 0) tick_gap = cycle_no - last_tick_cycle;
            last_tick_cycle = cycle_no;
            ticks++;
            if (ticks == 1) rl_at_tick1 = int'(bus.rotations_left);
        end
        if (bus.done === 1'b1) begin
            dones++;
            done_cycle = cycle_no;
        end
        s_start = 0; s_stop = 0; s_step_req = 0;
    endtask

    task automatic clear_book();
        ticks = 0; dones = 0; tick_gap = 0; last_tick_cycle = 0; done_cycle = 0; rl_at_tick1 = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, 32'(bus.addr), 32'd0);
        chk({tag, "_ce_oe_we"}, 32'({bus.ce_n, bus.oe_n, bus.we_n}), 32'b111);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_tick_done"}, 32'({bus.rotation_tick, bus.done}), 32'd0);
        chk({tag, "_rot_left"}, 32'(bus.rotations_left), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cycle;
        int nr_r;
        s_start = 0; s_stop = 0; s_step_mode = 0; s_step_req = 0; s_nr = 0;
        cycle_no = 0;
        model_reset();
        clear_book();
        bus.start = 0; bus.stop = 0; bus.step_mode = 0; bus.step_req = 0;
        bus.num_rotations = 0; bus.reset_counter_n = 1'bx;

        // reset state
        #12;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check_reset_outputs("idle");

        // two free-running rotations
        clear_book();
        s_nr = 8'd2; s_start = 1;
        step();
        chk("start_addr0", 32'({bus.addr, bus.busy, bus.ce_n}), 32'({6'd0, 1'b1, 1'b0}));
        step();
        chk("first_adv", 32'(bus.addr), 32'd1);
        for (int i = 0; i < 300 && m_busy; i++) step();
        chk("rot2_idle", 32'(bus.busy), 32'd0);
        chk("rot2_ticks", 32'(ticks), 32'd2);
        chk("rot2_gap", 32'(tick_gap), 32'(NP));
        chk("rot2_dones", 32'(dones), 32'd1);
        chk("rot2_rl_mid", 32'(rl_at_tick1), 32'd1);
        chk("rot2_tick_done", 32'(done_cycle), 32'(last_tick_cycle));

        // continuous run, stop at position 20, halt at end of rotation
        clear_book();
        s_nr = 8'd0; s_start = 1;
        step();
        start_cycle = cycle_no;
        for (int i = 0; i < 100 && m_addr != 20; i++) step();
        s_stop = 1;
        step();
        chk("stop_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 100 && m_busy; i++) step();
        chk("stop_len", 32'(done_cycle - start_cycle), 32'(NP));
        chk("stop_dones", 32'(dones), 32'd1);

        // memory reports end of rotation early at position 30
        clear_book();
        s_fault_addr = 30;
        s_nr = 8'd0; s_start = 1;
        step();
        start_cycle = cycle_no;
        for (int i = 0; i < 100 && ticks == 0; i++) step();
        chk("early_wrap_len", 32'(last_tick_cycle - start_cycle), 32'd31);
        chk("early_wrap_addr", 32'(bus.addr), 32'd0);
        s_stop = 1;
        for (int i = 0; i < 100 && m_busy; i++) step();
        chk("early_wrap_done", 32'(done_cycle - start_cycle), 32'd62);
        s_fault_addr = -1;

        // single-step mode
        clear_book();
        s_step_mode = 1; s_nr = 8'd0; s_start = 1;
        step();
        for (int k = 1; k <= 3; k++) begin
            s_step_req = 1;
            step();
            chk("step_addr", 32'(bus.addr), 32'(k));
            for (int j = 0; j < 4; j++) step();
            chk("step_hold", 32'({bus.addr, bus.ce_n}), 32'({6'(k), 1'b0}));
        end
        s_step_mode = 0;
        step();
        chk("step_toggle", 32'(bus.addr), 32'd4);
        s_stop = 1;
        for (int i = 0; i < 100 && m_busy; i++) step();
        chk("step_end", 32'(dones), 32'd1);

        // asynchronous reset mid-rotation
        clear_book();
        s_nr = 8'd0; s_start = 1;
        step();
        for (int i = 0; i < 100 && m_addr != 37; i++) step();
        chk("pre_rst_addr", 32'(bus.addr), 32'd37);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        #1 rst_n = 1'b1;
        step();
        chk("rst_no_done", 32'(dones), 32'd0);

        // restart; ignored start while busy; stop coincident with final wrap
        clear_book();
        s_nr = 8'd1; s_start = 1;
        step();
        chk("restart_addr0", 32'(bus.addr), 32'd0);
        step();
        chk("restart_addr1", 32'(bus.addr), 32'd1);
        for (int i = 0; i < 20 && m_addr != 10; i++) step();
        s_nr = 8'd5; s_start = 1;
        step();
        chk("busy_start_ign", 32'({bus.rotations_left, bus.addr}), 32'({8'd1, 6'd11}));
        for (int i = 0; i < 100 && m_addr != NP - 1; i++) step();
        s_stop = 1;
        step();
        chk("final_wrap_stop", 32'({bus.done, bus.busy}), 32'b10);
        for (int i = 0; i < 5; i++) step();
        chk("single_done", 32'(dones), 32'd1);

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            nr_r = int'($urandom_range(0, 2));
            s_nr = 8'(nr_r); s_step_mode = 0; s_start = 1;
            step();
            for (int i = 0; i < 250 && m_busy; i++) begin
                s_step_req   = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 19) == 0) s_step_mode = !s_step_mode;
                s_stop       = ($urandom_range(0, 59) == 0);
                s_fault_addr = ($urandom_range(0, 39) == 0) ? m_addr : -1;
                if ($urandom_range(0, 49) == 0) begin
                    s_start = 1;
                    s_nr    = 8'($urandom_range(0, 255));
                end
                step();
            end
            s_fault_addr = -1;
            s_step_mode  = 0;
            if (m_busy) s_stop = 1;
            for (int i = 0; i < 100 && m_busy; i++) step();
            chk("rand_end", 32'(bus.busy), 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
